// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: op codes, FSM states, funct7 constants and decode helpers for alu_exec_unit
package alu_exec_pkg;
  localparam logic [2:0] ALUOP_DECODE = 3'b111;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } alu_op_e;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
  function automatic alu_op_e base_op(input logic [2:0] f3);
    case (f3)
      3'b001: return OP_SLL;
      3'b010: return OP_SLT;
      3'b011: return OP_SLTU;
      3'b100: return OP_XOR;
      3'b101: return OP_SRL;
      3'b110: return OP_OR;
      3'b111: return OP_AND;
      default: return OP_ADD;
    endcase
  endfunction
  function automatic alu_op_e decode(input logic [2:0] aop, input logic src, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic mdu);
    if (aop != ALUOP_DECODE) return alu_op_e'({2'b00, aop});
    if (src) return (f3 == 3'b101) ? (f7[5] ? OP_SRA : OP_SRL) : base_op(f3);
    if (f7 == F7_BASE) return base_op(f3);
    if (f7 == F7_ALT) return (f3 == 3'b000) ? OP_SUB : (f3 == 3'b101) ? OP_SRA : OP_ADD;
    if (f7 == F7_MULDIV && mdu) return alu_op_e'(5'd10 + {2'b00, f3});
    return OP_ADD;
  endfunction
  function automatic logic is_mdu(input alu_op_e op);
    return op >= OP_MUL;
  endfunction
  function automatic logic is_div(input alu_op_e op);
    return op >= OP_DIV;
  endfunction
endpackage

// File: rtl/alu_exec_mdu.sv
// alu_exec_mdu: iterative shift-add multiplier / restoring divider, one bit per cycle
module alu_exec_mdu
  import alu_exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] res
);
  localparam int CW = $clog2(XLEN);
  logic busy, div, neg, hi, sa, sb;
  logic [CW-1:0] cnt;
  logic [2*XLEN-1:0] acc, nxt, prod;
  logic [XLEN-1:0] m, ma, mb, half;
  logic [XLEN:0] sum, sh, diff;
  assign sa = (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM) && a[XLEN-1];
  assign sb = (op == OP_MULH || op == OP_DIV || op == OP_REM) && b[XLEN-1];
  assign ma = sa ? -a : a;
  assign mb = sb ? -b : b;
  assign sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, {XLEN{acc[0]}} & m};
  assign sh = acc[2*XLEN-1:XLEN-1];
  assign diff = sh - {1'b0, m};
  assign nxt = !div ? {sum, acc[XLEN-1:1]} :
               diff[XLEN] ? {sh[XLEN-1:0], acc[XLEN-2:0], 1'b0} : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  assign prod = neg ? -nxt : nxt;
  assign half = hi ? nxt[2*XLEN-1:XLEN] : nxt[XLEN-1:0];
  assign res = div ? (neg ? -half : half) : (hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0]);
  assign done = busy && cnt == CW'(XLEN - 1);
  // Load operand magnitudes on start, then step the shared accumulator once per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      div <= 1'b0;
      neg <= 1'b0;
      hi <= 1'b0;
      cnt <= '0;
      acc <= '0;
      m <= '0;
    end else if (flush) begin
      busy <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= '0;
      div <= is_div(op);
      hi <= op == OP_MULH || op == OP_MULHSU || op == OP_MULHU || op == OP_REM || op == OP_REMU;
      neg <= (op == OP_REM || op == OP_REMU) ? sa : sa ^ sb;
      acc <= {{XLEN{1'b0}}, ma};
      m <= mb;
    end else if (busy) begin
      acc <= nxt;
      cnt <= cnt + 1'b1;
      busy <= !done;
    end
  end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32I/M execute stage with registered valid/ready result
// ALU_EXEC_FAST_MUL_EN: single-cycle combinational multiply; divide stays iterative
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit MDU_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      alu_op,
  input  logic            alu_src,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            stall
);
  localparam int SW = $clog2(XLEN);
  state_e state;
  alu_op_e op;
  logic accept, iter, special, div_zero, div_ovf, mdu_done;
  logic [XLEN-1:0] alu_res, mdu_res;
  logic [SW-1:0] sh;
  assign op = decode(alu_op, alu_src, funct3, funct7, MDU_EN);
  assign sh = op_b[SW-1:0];
  assign in_ready = state == S_IDLE && !(out_valid && !out_ready);
  assign accept = in_valid && in_ready && !flush;
  assign div_zero = op_b == '0;
  assign div_ovf = (op == OP_DIV || op == OP_REM) && op_a == {1'b1, {XLEN-1{1'b0}}} && op_b == '1;
  assign special = is_div(op) && (div_zero || div_ovf);
`ifdef ALU_EXEC_FAST_MUL_EN
  logic [2*XLEN-1:0] fa, fb, fp;
  assign fa = {{XLEN{(op == OP_MULH || op == OP_MULHSU) && op_a[XLEN-1]}}, op_a};
  assign fb = {{XLEN{op == OP_MULH && op_b[XLEN-1]}}, op_b};
  assign fp = fa * fb;
  assign iter = is_div(op) && !special;
`else
  assign iter = is_mdu(op) && !special;
`endif
  assign stall = state == S_MUL || state == S_DIV || (accept && iter);
  // Single-cycle ALU, including the divide corner cases that bypass the engine
  always_comb begin
    case (op)
      OP_SUB: alu_res = op_a - op_b;
      OP_AND: alu_res = op_a & op_b;
      OP_OR: alu_res = op_a | op_b;
      OP_XOR: alu_res = op_a ^ op_b;
      OP_SLT: alu_res = {{XLEN-1{1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU: alu_res = {{XLEN-1{1'b0}}, op_a < op_b};
      OP_SLL: alu_res = op_a << sh;
      OP_SRL: alu_res = op_a >> sh;
      OP_SRA: alu_res = $signed(op_a) >>> sh;
      OP_DIV, OP_DIVU: alu_res = div_zero ? '1 : op_a;
      OP_REM, OP_REMU: alu_res = div_zero ? op_a : '0;
`ifdef ALU_EXEC_FAST_MUL_EN
      OP_MUL: alu_res = fp[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: alu_res = fp[2*XLEN-1:XLEN];
`endif
      default: alu_res = op_a + op_b;
    endcase
  end
  alu_exec_mdu #(.XLEN(XLEN)) u_mdu (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .start(accept && iter),
    .op(op),
    .a(op_a),
    .b(op_b),
    .done(mdu_done),
    .res(mdu_res)
  );
  // Control FSM owning the output register and out_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      out_valid <= 1'b0;
      result <= '0;
    end else if (flush) begin
      state <= S_IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE:
          if (accept && iter) begin
            state <= is_div(op) ? S_DIV : S_MUL;
            out_valid <= 1'b0;
          end else if (accept) begin
            result <= alu_res;
            out_valid <= 1'b1;
          end else if (out_ready) out_valid <= 1'b0;
        S_MUL, S_DIV:
          if (mdu_done) begin
            state <= S_DONE;
            result <= mdu_res;
            out_valid <= 1'b1;
          end
        default:
          if (out_ready) begin
            state <= S_IDLE;
            out_valid <= 1'b0;
          end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: scoreboard bench for alu_exec_unit (XLEN=32, MDU_EN=1)
module tb_alu_exec_unit;
`ifdef ALU_EXEC_FAST_MUL_EN
  localparam int ML = 1;
`else
  localparam int ML = 33;
`endif
  localparam int DL = 33;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, in_ready, alu_src = 0;
  logic out_valid, out_ready = 1, stall;
  logic [2:0] alu_op = 0, funct3 = 0;
  logic [6:0] funct7 = 0;
  logic [31:0] op_a = 0, op_b = 0, result;
  logic [31:0] exp_q[$];
  int checks = 0, errors = 0;

  alu_exec_unit dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .alu_src(alu_src), .funct3(funct3), .funct7(funct7),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [2:0] aop, input logic src, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int n = 0;
    alu_op = aop; alu_src = src; funct3 = f3; funct7 = f7; op_a = a; op_b = b; in_valid = 1;
    @(negedge clk);
    while (!in_ready && n < 100) begin n++; @(negedge clk); end
    check("accept", 32'(in_ready), 32'd1);
    exp_q.push_back(exp);
    @(posedge clk); #1 in_valid = 0;
  endtask

  task automatic mop(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int lat);
    int k = 1;
    int nst = 0;
    send(3'd7, 1'b0, f3, 7'h01, a, b, exp);
    @(negedge clk);
    while (!out_valid && k < 100) begin if (stall) nst++; k++; @(negedge clk); end
    check("m_latency", 32'(k), 32'(lat));
    check("m_stall_cycles", 32'(nst), 32'(lat - 1));
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      check("q_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("result", result, exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int sum;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 rst = 0;
    send(3'd7, 0, 3'd0, 7'h20, 32'd5, 32'd7, 32'hFFFFFFFE);
    check("sub_latency", 32'(out_valid), 32'd1);
    send(3'd7, 1, 3'd5, 7'h20, 32'h80000000, 32'd4, 32'hF8000000);
    send(3'd7, 0, 3'd5, 7'h20, 32'h80000000, 32'd4, 32'hF8000000);
    send(3'd7, 1, 3'd5, 7'h00, 32'h80000000, 32'd4, 32'h08000000);
    send(3'd7, 0, 3'd1, 7'h00, 32'd1, 32'h21, 32'd2);
    send(3'd7, 0, 3'd2, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd1);
    send(3'd7, 0, 3'd3, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd0);
    send(3'd7, 1, 3'd0, 7'h20, 32'd5, 32'd7, 32'd12);
    send(3'd7, 0, 3'd1, 7'h20, 32'd5, 32'd7, 32'd12);
    send(3'd7, 0, 3'd6, 7'h00, 32'hF0, 32'h0F, 32'hFF);
    send(3'd7, 0, 3'd7, 7'h00, 32'hFF, 32'h0F, 32'h0F);
    send(3'd7, 0, 3'd4, 7'h00, 32'hFF, 32'h0F, 32'hF0);
    send(3'd0, 0, 3'd0, 7'h00, 32'd1, 32'd2, 32'd3);
    send(3'd1, 0, 3'd0, 7'h00, 32'd10, 32'd3, 32'd7);
    send(3'd2, 0, 3'd0, 7'h00, 32'hC, 32'hA, 32'h8);
    send(3'd3, 0, 3'd0, 7'h00, 32'hC, 32'hA, 32'hE);
    send(3'd4, 0, 3'd0, 7'h00, 32'hC, 32'hA, 32'h6);
    send(3'd5, 0, 3'd0, 7'h00, 32'h80000000, 32'd1, 32'd1);
    send(3'd6, 0, 3'd0, 7'h00, 32'h80000000, 32'd1, 32'd0);
    @(posedge clk); #1;
    mop(3'd0, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, ML);
    mop(3'd3, 32'hFFFFFFFF, 32'd2, 32'h00000001, ML);
    mop(3'd1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, ML);
    mop(3'd0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, ML);
    mop(3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, ML);
    mop(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, ML);
    mop(3'd5, 32'd100, 32'd7, 32'd14, DL);
    mop(3'd4, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, DL);
    mop(3'd6, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, DL);
    mop(3'd7, 32'd100, 32'd7, 32'd2, DL);
    mop(3'd5, 32'h80000000, 32'hFFFFFFFF, 32'd0, DL);
    mop(3'd4, 32'd17, 32'd0, 32'hFFFFFFFF, 1);
    mop(3'd7, 32'd17, 32'd0, 32'd17, 1);
    mop(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
    mop(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    alu_op = 3'd7; alu_src = 0; funct3 = 3'd5; funct7 = 7'h01; op_a = 32'd100; op_b = 32'd7; in_valid = 1;
    @(negedge clk);
    check("flush_pre_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 in_valid = 0;
    repeat (9) @(posedge clk);
    #1 flush = 1; in_valid = 1; alu_op = 3'd0; op_a = 32'd3; op_b = 32'd3;
    @(posedge clk); #1 flush = 0; in_valid = 0;
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_stall", 32'(stall), 32'd0);
    sum = 0;
    for (int i = 0; i < 40; i++) begin if (out_valid) sum++; @(negedge clk); end
    check("flush_no_out", 32'(sum), 32'd0);
    @(posedge clk); #1;
    send(3'd0, 0, 3'd0, 7'h00, 32'd1, 32'd1, 32'd2);
    @(posedge clk); #1 flush = 1; in_valid = 1; alu_op = 3'd0; op_a = 32'd3; op_b = 32'd3;
    @(posedge clk); #1 flush = 0; in_valid = 0;
    @(negedge clk);
    check("flush_op_dropped", 32'(out_valid), 32'd0);
    @(posedge clk); #1 out_ready = 0;
    send(3'd0, 0, 3'd0, 7'h00, 32'd10, 32'd20, 32'd30);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_result", result, 32'd30);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1 out_ready = 1;
    send(3'd4, 0, 3'd0, 7'h00, 32'hF0, 32'hFF, 32'h0F);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_valid_drop", 32'(out_valid), 32'd0);
    @(posedge clk); #1 alu_op = 3'd7; funct3 = 3'd0; funct7 = 7'h01; op_a = 32'd3; op_b = 32'd4; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    repeat (5) @(posedge clk);
    #3 rst = 1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_stall", 32'(stall), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_result", result, 32'd0);
    @(posedge clk); #1 rst = 0;
    send(3'd0, 0, 3'd0, 7'h00, 32'd40, 32'd2, 32'd42);
    repeat (3) @(posedge clk);
    #1 check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
